// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants and FSM state type for the scan capture block.
package seg7_pkg;
  typedef logic [6:0] seg_pat_t;
  localparam seg_pat_t SEG_0     = 7'h7E;
  localparam seg_pat_t SEG_1     = 7'h30;
  localparam seg_pat_t SEG_2     = 7'h6D;
  localparam seg_pat_t SEG_3     = 7'h79;
  localparam seg_pat_t SEG_4     = 7'h33;
  localparam seg_pat_t SEG_5     = 7'h5B;
  localparam seg_pat_t SEG_6     = 7'h1F;
  localparam seg_pat_t SEG_7     = 7'h70;
  localparam seg_pat_t SEG_8     = 7'h7F;
  localparam seg_pat_t SEG_9     = 7'h73;
  localparam seg_pat_t SEG_A     = 7'h77;
  localparam seg_pat_t SEG_B     = 7'h1F;
  localparam seg_pat_t SEG_C     = 7'h4E;
  localparam seg_pat_t SEG_D     = 7'h3D;
  localparam seg_pat_t SEG_E     = 7'h4F;
  localparam seg_pat_t SEG_F     = 7'h47;
  localparam seg_pat_t SEG_6_ALT = 7'h5F;
  localparam seg_pat_t SEG_9_ALT = 7'h7B;
  localparam seg_pat_t SEG_BLANK = 7'h00;
  typedef enum logic {SETTLE, HOLD} state_t;
endpackage

// File: rtl/seg7_encode.sv
// seg7_encode: maps an active-high a..g segment pattern back to a hex nibble.
module seg7_encode
  import seg7_pkg::*;
(
  input  seg_pat_t   pat,
  output logic       hit,
  output logic       blank,
  output logic       ambig,
  output logic [3:0] nibble
);
  always_comb begin
    hit = 1'b1;
    ambig = 1'b0;
    nibble = 4'h0;
    blank = pat == SEG_BLANK;
    case (pat)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      // cdefg is both 6 and b; report b and flag it
      SEG_B: begin
        nibble = 4'hB;
        ambig = 1'b1;
      end
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      SEG_6_ALT: nibble = 4'h6;
      SEG_9_ALT: nibble = 4'h9;
      default: hit = 1'b0;
    endcase
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: samples a multiplexed active-low 7-segment bus and rebuilds the digit values.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   bad_pattern,
  output logic [NUM_DIGITS-1:0]   ambig,
  output logic                    frame_valid
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [NUM_DIGITS+6:0] r;
  logic [NUM_DIGITS-1:0] an, seen, seen_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic same, commit, fire, hit, blank, amb;
  state_t state, state_n;

  seg7_encode u_enc (
    .pat(~r[6:0]),
    .hit(hit),
    .blank(blank),
    .ambig(amb),
    .nibble(nib)
  );

  // the registered sample is compared with the live pins, so the count
  // covers STABLE_CYCLES consecutive identical registered samples
  always_comb begin
    same = {an_n, seg_n} == r;
    an = ~r[NUM_DIGITS+6:7];
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) if (an[i]) idx = IW'(i);
    cnt_inc = cnt == CW'(STABLE_CYCLES) ? cnt : cnt + CW'(1);
    state_n = state;
    cnt_n = cnt;
    commit = 1'b0;
    if (!same) begin
      cnt_n = '0;
      state_n = SETTLE;
    end else if (state == SETTLE) begin
      cnt_n = cnt_inc;
      if (cnt_inc == CW'(STABLE_CYCLES)) begin
        state_n = HOLD;
        commit = $onehot(an);
      end
    end
    seen_n = commit ? seen | (NUM_DIGITS'(1) << idx) : seen;
    fire = commit && &seen_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '1;
      cnt <= '0;
      state <= SETTLE;
      seen <= '0;
      value <= '0;
      digit_valid <= '0;
      bad_pattern <= '0;
      ambig <= '0;
      frame_valid <= 1'b0;
    end else begin
      r <= {an_n, seg_n};
      cnt <= cnt_n;
      state <= state_n;
      seen <= fire ? '0 : seen_n;
      frame_valid <= fire;
      if (commit) begin
        value[4*idx +: 4] <= hit ? nib : 4'h0;
        digit_valid[idx] <= hit;
        bad_pattern[idx] <= !hit && !blank;
        ambig[idx] <= amb;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed and randomized checks against a run-length reference model.
module tb_seg7_scan_capture;
  localparam int ND = 4;
  localparam int STABLE = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [ND-1:0] an_n = '1;
  logic [6:0] seg_n = '1;
  logic [4*ND-1:0] value;
  logic [ND-1:0] digit_valid, bad_pattern, ambig;
  logic frame_valid;
  int checks = 0;
  int failures = 0;

  seg7_scan_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(STABLE)) dut (
    .clk(clk),
    .rst(rst),
    .an_n(an_n),
    .seg_n(seg_n),
    .value(value),
    .digit_valid(digit_valid),
    .bad_pattern(bad_pattern),
    .ambig(ambig),
    .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  string names[18] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "cdefg", "abc", "abcdefg",
                       "abcfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg", "acdefg", "abcdfg"};

  logic [15:0] m_value;
  logic [3:0] m_valid, m_bad, m_amb, m_seen;
  logic m_frame;
  logic [10:0] m_prev;
  int m_run;
  wire [28:0] obs = {value, digit_valid, bad_pattern, ambig, frame_valid};

  function automatic logic [6:0] lit_of(input string s);
    logic [6:0] p = '0;
    for (int i = 0; i < s.len(); i++) p[6 - (s[i] - "a")] = 1'b1;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input int j);
    return ~lit_of(names[j]);
  endfunction

  function automatic logic [28:0] exp_vec();
    return {m_value, m_valid, m_bad, m_amb, m_frame};
  endfunction

  // a commit happens on the edge where the same pins have been seen for STABLE+1 edges in a row
  task automatic model_edge();
    int k, nib;
    logic v, b, a;
    logic [6:0] lit;
    if (rst) begin
      m_prev = '1;
      m_run = 1;
      {m_value, m_valid, m_bad, m_amb, m_seen, m_frame} = '0;
    end else begin
      m_run = ({an_n, seg_n} == m_prev) ? m_run + 1 : 1;
      m_prev = {an_n, seg_n};
      m_frame = 1'b0;
      if (m_run == STABLE + 1 && $countones(~an_n) == 1) begin
        k = 0;
        for (int i = 0; i < ND; i++) if (!an_n[i]) k = i;
        lit = ~seg_n;
        nib = 0; v = 1'b0; b = lit != 0; a = 1'b0;
        for (int j = 17; j >= 0; j--)
          if (lit == lit_of(names[j])) begin
            v = 1'b1; b = 1'b0;
            nib = j < 16 ? j : (j == 16 ? 6 : 9);
            a = (j == 6 || j == 11);
            if (a) nib = 11;
          end
        m_value[4*k +: 4] = 4'(nib);
        m_valid[k] = v;
        m_bad[k] = b;
        m_amb[k] = a;
        m_seen[k] = 1'b1;
        if (&m_seen) begin
          m_frame = 1'b1;
          m_seen = '0;
        end
      end
    end
  endtask

  task automatic step(input logic [ND-1:0] an, input logic [6:0] sg, input logic rs);
    @(negedge clk);
    an_n = an;
    seg_n = sg;
    rst = rs;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    step('1, '1, 1'b1);
    step('1, '1, 1'b1);
  endtask

  task automatic test_reset();
    logic [ND-1:0] an = ~(ND'(1) << $urandom_range(ND - 1));
    logic [6:0] sg = seg_of($urandom_range(17));
    step(4'($urandom), 7'($urandom), 1'b1);
    step(an, sg, 1'b1);
    checks++;
    if (obs !== '0) begin $display("FAIL reset_outputs got=%h exp=0", obs); failures++; end
    for (int e = 1; e <= STABLE + 1; e++) begin
      step(an, sg, 1'b0);
      checks++;
      if (obs !== exp_vec() || (e <= STABLE && obs !== '0)) begin
        $display("FAIL reset_release_edge%0d got=%h exp=%h", e, obs, exp_vec()); failures++;
      end
    end
    checks++;
    if (digit_valid !== ~an) begin $display("FAIL reset_first_commit got=%b exp=%b", digit_valid, ~an); failures++; end
  endtask

  task automatic test_single();
    do_reset();
    for (int e = 1; e <= 5; e++) begin
      step(4'b1110, 7'b0000110, 1'b0);
      if (e == 4) begin
        checks++;
        if (digit_valid !== 4'b0000) begin $display("FAIL single_edge4 got=%b exp=0000", digit_valid); failures++; end
      end
    end
    checks++;
    if (value[3:0] !== 4'h3 || digit_valid !== 4'b0001) begin
      $display("FAIL single_edge5 got=%h/%b exp=3/0001", value[3:0], digit_valid); failures++;
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(4'b1110, e <= 3 ? 7'b0000110 : 7'b1001111, 1'b0);
      checks++;
      if (e < 8 && (value !== '0 || digit_valid !== '0)) begin
        $display("FAIL glitch_no_commit e%0d got=%h/%b exp=0/0", e, value, digit_valid); failures++;
      end else if (e == 8 && (value[3:0] !== 4'h1 || digit_valid !== 4'b0001)) begin
        $display("FAIL glitch_commit got=%h/%b exp=1/0001", value[3:0], digit_valid); failures++;
      end
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] ans[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    int digs[4] = '{1, 2, 10, 15};
    int pulses = 0;
    do_reset();
    for (int d = 0; d < 4; d++)
      for (int c = 1; c <= 8; c++) begin
        step(ans[d], seg_of(digs[d]), 1'b0);
        if (frame_valid) pulses++;
        if (d == 3 && c == 5) begin
          checks++;
          if (frame_valid !== 1'b1) begin $display("FAIL scan_frame_at_d3 got=%b exp=1", frame_valid); failures++; end
        end
      end
    checks++;
    if (value !== 16'hFA21 || digit_valid !== 4'hF || pulses != 1) begin
      $display("FAIL scan_result got=%h/%h/%0d exp=FA21/F/1", value, digit_valid, pulses); failures++;
    end
  endtask

  task automatic test_classes();
    logic [6:0] pats[3] = '{7'b1100000, 7'b0111111, 7'b1111111};
    logic [6:0] want[3] = '{7'b1011_1_0_1, 7'b0000_0_1_0, 7'b0000_0_0_0};
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 8; c++) step(4'b1101, pats[p], 1'b0);
      checks++;
      if ({value[7:4], digit_valid[1], bad_pattern[1], ambig[1]} !== want[p]) begin
        $display("FAIL class%0d got=%b exp=%b", p, {value[7:4], digit_valid[1], bad_pattern[1], ambig[1]}, want[p]);
        failures++;
      end
    end
  endtask

  task automatic test_anode_faults();
    do_reset();
    for (int c = 0; c < 8; c++) step(4'b1011, 7'b0100100, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(4'b1100, 7'b0000000, 1'b0);
      checks++;
      if (value !== 16'h0500 || digit_valid !== 4'b0100 || frame_valid !== 1'b0) begin
        $display("FAIL multi_anode c%0d got=%h/%b exp=0500/0100", c, value, digit_valid); failures++;
      end
    end
    for (int c = 0; c < 3; c++) step(4'b1110, 7'b0000000, 1'b0);
    step(4'b1110, 7'b0000000, 1'b1);
    checks++;
    if (obs !== '0) begin $display("FAIL mid_dwell_reset got=%h exp=0", obs); failures++; end
    for (int e = 1; e <= 5; e++) begin
      step(4'b1110, 7'b0000000, 1'b0);
      checks++;
      if (e < 5 && obs !== '0) begin
        $display("FAIL post_reset_early e%0d got=%h exp=0", e, obs); failures++;
      end else if (e == 5 && (value !== 16'h0008 || digit_valid !== 4'b0001)) begin
        $display("FAIL post_reset_commit got=%h/%b exp=0008/0001", value, digit_valid); failures++;
      end
    end
  endtask

  task automatic test_random();
    logic [ND-1:0] an;
    logic [6:0] sg;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      an = $urandom_range(9) == 0 ? 4'($urandom) : ~(ND'(1) << $urandom_range(ND - 1));
      sg = $urandom_range(7) == 0 ? 7'($urandom) : seg_of($urandom_range(17));
      for (int c = $urandom_range(1, 10); c > 0; c--) begin
        step(an, sg, 1'b0);
        checks++;
        if (obs !== exp_vec()) begin $display("FAIL random n%0d got=%h exp=%h", n, obs, exp_vec()); failures++; end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_full_scan();
    test_classes();
    test_anode_faults();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
